// File: rtl/cpu_hazard_ctrl.sv
// Hazard detection and operand forwarding control for the 5-step pipeline.
// Tracks the destinations of the instructions in steps 3..5 against the step-2 reader.
module cpu_hazard_ctrl #(
  parameter int WIDTH          = 32,
  parameter int REGFILE_BYPASS = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     instr_step_2,
  input  logic                 valid_step_2,
  input  logic                 branch_taken_step_3,
  input  logic                 mem_busy,
  output logic                 is_send_from_alu_rs,
  output logic                 is_send_from_alu_rt,
  output logic                 is_send_from_mem_rs,
  output logic                 is_send_from_mem_rt,
  output logic                 control_mux_for_rt_rd,
  output logic                 control_mux_for_wnum,
  output logic [4:0]           wnum_step_5,
  output logic                 is_write_reg,
  output logic                 stall_step_2,
  output logic                 flush_step_2,
  output logic                 bubble_step_3,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam bit Bypass = (REGFILE_BYPASS != 0);

  logic [5:0] opcode;
  logic [4:0] rsNum, rtNum, rdNum;
  logic       unusedInstrBits;

  assign opcode          = instr_step_2[31:26];
  assign rsNum           = instr_step_2[25:21];
  assign rtNum           = instr_step_2[20:16];
  assign rdNum           = instr_step_2[15:11];
  assign unusedInstrBits = ^instr_step_2[10:0];

  logic       readsRs, readsRt, writesReg, isLoad;
  logic [4:0] dstNum;

  always_comb begin
    readsRs   = 1'b0;
    readsRt   = 1'b0;
    writesReg = 1'b0;
    isLoad    = 1'b0;
    dstNum    = rtNum;
    case (opcode)
      6'h00: begin
        readsRs   = 1'b1;
        readsRt   = 1'b1;
        writesReg = 1'b1;
        dstNum    = rdNum;
      end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        readsRs   = 1'b1;
        writesReg = 1'b1;
      end
      6'h23: begin
        readsRs   = 1'b1;
        writesReg = 1'b1;
        isLoad    = 1'b1;
      end
      6'h2B, 6'h04, 6'h05: begin
        readsRs = 1'b1;
        readsRt = 1'b1;
      end
      default: ;
    endcase
    // r0 is hardwired, so a write to it is never a producer
    if (dstNum == 5'd0) writesReg = 1'b0;
  end

  logic       v3_q, w3_q, ld3_q, v4_q, w4_q, ld4_q, v5_q, w5_q, ld5_q;
  logic [4:0] dst3_q, dst4_q, dst5_q;
  logic       v3_d, w3_d, ld3_d, v4_d, w4_d, ld4_d, v5_d, w5_d, ld5_d;
  logic [4:0] dst3_d, dst4_d, dst5_d;
  logic [CNT_WIDTH-1:0] stallCnt_q, stallCnt_d, flushCnt_q, flushCnt_d;

  logic m3Rs, m3Rt, m4Rs, m4Rt, m5Rs, m5Rt;
  assign m3Rs = readsRs & v3_q & w3_q & (dst3_q == rsNum) & (rsNum != 5'd0);
  assign m3Rt = readsRt & v3_q & w3_q & (dst3_q == rtNum) & (rtNum != 5'd0);
  assign m4Rs = readsRs & v4_q & w4_q & (dst4_q == rsNum) & (rsNum != 5'd0);
  assign m4Rt = readsRt & v4_q & w4_q & (dst4_q == rtNum) & (rtNum != 5'd0);
  assign m5Rs = readsRs & v5_q & w5_q & (dst5_q == rsNum) & (rsNum != 5'd0);
  assign m5Rt = readsRt & v5_q & w5_q & (dst5_q == rtNum) & (rtNum != 5'd0);

  logic loadUse, step5Hazard, hz;
  assign loadUse     = (m3Rs | m3Rt) & ld3_q;
  assign step5Hazard = !Bypass & ((m5Rs & !m3Rs & !m4Rs) | (m5Rt & !m3Rt & !m4Rt));
  // a taken branch squashes the reader anyway, so it never needs to wait
  assign hz          = valid_step_2 & (loadUse | step5Hazard) & !branch_taken_step_3;

  assign is_send_from_alu_rs   = m3Rs & !ld3_q;
  assign is_send_from_alu_rt   = m3Rt & !ld3_q;
  assign is_send_from_mem_rs   = m4Rs & !m3Rs;
  assign is_send_from_mem_rt   = m4Rt & !m3Rt;
  assign control_mux_for_rt_rd = (opcode == 6'h00);
  assign control_mux_for_wnum  = 1'b1;
  assign wnum_step_5           = dst5_q;
  assign is_write_reg          = v5_q & w5_q & !mem_busy;
  assign stall_step_2          = hz | mem_busy;
  assign bubble_step_3         = (hz | branch_taken_step_3) & !mem_busy;
  assign flush_step_2          = branch_taken_step_3 & !mem_busy;
  assign stall_cnt             = stallCnt_q;
  assign flush_cnt             = flushCnt_q;

  always_comb begin
    v3_d = v3_q;  w3_d = w3_q;  dst3_d = dst3_q;  ld3_d = ld3_q;
    v4_d = v4_q;  w4_d = w4_q;  dst4_d = dst4_q;  ld4_d = ld4_q;
    v5_d = v5_q;  w5_d = w5_q;  dst5_d = dst5_q;  ld5_d = ld5_q;
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (!mem_busy) begin
      v5_d = v4_q;  w5_d = w4_q;  dst5_d = dst4_q;  ld5_d = ld4_q;
      v4_d = v3_q;  w4_d = w3_q;  dst4_d = dst3_q;  ld4_d = ld3_q;
      if (bubble_step_3) begin
        v3_d = 1'b0;  w3_d = 1'b0;  dst3_d = 5'd0;  ld3_d = 1'b0;
      end else begin
        v3_d = valid_step_2;  w3_d = writesReg;  dst3_d = dstNum;  ld3_d = isLoad;
      end
      if (hz && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + CNT_WIDTH'(1);
      if (flush_step_2 && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q <= 1'b0;  w3_q <= 1'b0;  dst3_q <= 5'd0;  ld3_q <= 1'b0;
      v4_q <= 1'b0;  w4_q <= 1'b0;  dst4_q <= 5'd0;  ld4_q <= 1'b0;
      v5_q <= 1'b0;  w5_q <= 1'b0;  dst5_q <= 5'd0;  ld5_q <= 1'b0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      v3_q <= v3_d;  w3_q <= w3_d;  dst3_q <= dst3_d;  ld3_q <= ld3_d;
      v4_q <= v4_d;  w4_q <= w4_d;  dst4_q <= dst4_d;  ld4_q <= ld4_d;
      v5_q <= v5_d;  w5_q <= w5_d;  dst5_q <= dst5_d;  ld5_q <= ld5_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Bench for cpu_hazard_ctrl: one instance without and one with register-file bypass
// (the latter with 2-bit counters), both checked every cycle against a pipeline model.
module tb_cpu_hazard_ctrl;

  logic        clk, rst, valid, branch, memBusy;
  logic [31:0] instr;

  logic aluRsA, aluRtA, memRsA, memRtA, rtRdA, wnumMuxA, wrA, stallA, flushA, bubbleA;
  logic aluRsB, aluRtB, memRsB, memRtB, rtRdB, wnumMuxB, wrB, stallB, flushB, bubbleB;
  logic [4:0]  wnumA, wnumB;
  logic [15:0] stallCntA, flushCntA;
  logic [1:0]  stallCntB, flushCntB;

  cpu_hazard_ctrl #(.WIDTH(32), .REGFILE_BYPASS(0), .CNT_WIDTH(16)) dutA (
    .clk(clk), .rst(rst), .instr_step_2(instr), .valid_step_2(valid),
    .branch_taken_step_3(branch), .mem_busy(memBusy),
    .is_send_from_alu_rs(aluRsA), .is_send_from_alu_rt(aluRtA),
    .is_send_from_mem_rs(memRsA), .is_send_from_mem_rt(memRtA),
    .control_mux_for_rt_rd(rtRdA), .control_mux_for_wnum(wnumMuxA),
    .wnum_step_5(wnumA), .is_write_reg(wrA), .stall_step_2(stallA),
    .flush_step_2(flushA), .bubble_step_3(bubbleA),
    .stall_cnt(stallCntA), .flush_cnt(flushCntA));

  cpu_hazard_ctrl #(.WIDTH(32), .REGFILE_BYPASS(1), .CNT_WIDTH(2)) dutB (
    .clk(clk), .rst(rst), .instr_step_2(instr), .valid_step_2(valid),
    .branch_taken_step_3(branch), .mem_busy(memBusy),
    .is_send_from_alu_rs(aluRsB), .is_send_from_alu_rt(aluRtB),
    .is_send_from_mem_rs(memRsB), .is_send_from_mem_rt(memRtB),
    .control_mux_for_rt_rd(rtRdB), .control_mux_for_wnum(wnumMuxB),
    .wnum_step_5(wnumB), .is_write_reg(wrB), .stall_step_2(stallB),
    .flush_step_2(flushB), .bubble_step_3(bubbleB),
    .stall_cnt(stallCntB), .flush_cnt(flushCntB));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic v; logic w; logic [4:0] dst; logic ld;
  } entry_t;

  typedef struct packed {
    logic rdRs; logic rdRt; logic wr; logic ld; logic [4:0] dst;
  } dec_t;

  typedef struct packed {
    logic aluRs; logic aluRt; logic memRs; logic memRt; logic rtRd; logic wnumMux;
    logic [4:0] wnum; logic wr; logic stall; logic flush; logic bubble;
    logic [15:0] stallCnt; logic [15:0] flushCnt; logic hz;
  } out_t;

  // pipe[id][0..2] holds what the model believes sits in steps 3..5
  entry_t pipe [2][3];
  int     stallCount [2];
  int     flushCount [2];
  bit     modelReady = 1'b0;
  int     testsRun = 0;
  int     testsFailed = 0;

  function automatic int cntMax(input int id);
    return (id == 0) ? 65535 : 3;
  endfunction

  function automatic dec_t decodeInstr(input logic [31:0] ins);
    dec_t d;
    d = '0;
    d.dst = ins[20:16];
    case (ins[31:26])
      6'h00: begin d.rdRs = 1; d.rdRt = 1; d.wr = 1; d.dst = ins[15:11]; end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin d.rdRs = 1; d.wr = 1; end
      6'h23: begin d.rdRs = 1; d.wr = 1; d.ld = 1; end
      6'h2B, 6'h04, 6'h05: begin d.rdRs = 1; d.rdRt = 1; end
      default: ;
    endcase
    d.wr = d.wr && (d.dst != 5'd0);
    return d;
  endfunction

  // youngest step (3..5) whose instruction writes r, or 0 when none does
  function automatic int producer(input int id, input logic [4:0] r);
    for (int i = 0; i < 3; i++)
      if (pipe[id][i].v && pipe[id][i].w && pipe[id][i].dst == r && r != 5'd0) return i + 3;
    return 0;
  endfunction

  function automatic out_t expected(input int id);
    out_t e;
    dec_t d;
    int   pRs, pRt;
    logic loadUse, step5;
    d   = decodeInstr(instr);
    pRs = d.rdRs ? producer(id, instr[25:21]) : 0;
    pRt = d.rdRt ? producer(id, instr[20:16]) : 0;
    e = '0;
    e.aluRs   = (pRs == 3) && !pipe[id][0].ld;
    e.aluRt   = (pRt == 3) && !pipe[id][0].ld;
    e.memRs   = (pRs == 4);
    e.memRt   = (pRt == 4);
    loadUse   = ((pRs == 3) || (pRt == 3)) && pipe[id][0].ld;
    step5     = (id == 0) && ((pRs == 5) || (pRt == 5));
    e.hz      = valid && (loadUse || step5) && !branch;
    e.stall   = e.hz || memBusy;
    e.bubble  = (e.hz || branch) && !memBusy;
    e.flush   = branch && !memBusy;
    e.wr      = pipe[id][2].v && pipe[id][2].w && !memBusy;
    e.wnum    = pipe[id][2].dst;
    e.rtRd    = (instr[31:26] == 6'h00);
    e.wnumMux = 1'b1;
    e.stallCnt = 16'(stallCount[id]);
    e.flushCnt = 16'(flushCount[id]);
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int id = 0; id < 2; id++) begin
        for (int i = 0; i < 3; i++) pipe[id][i] = '0;
        stallCount[id] = 0;
        flushCount[id] = 0;
      end
      modelReady = 1'b1;
    end else if (!memBusy) begin
      for (int id = 0; id < 2; id++) begin
        out_t e;
        dec_t d;
        e = expected(id);
        d = decodeInstr(instr);
        if (e.hz && stallCount[id] < cntMax(id)) stallCount[id]++;
        if (e.flush && flushCount[id] < cntMax(id)) flushCount[id]++;
        pipe[id][2] = pipe[id][1];
        pipe[id][1] = pipe[id][0];
        pipe[id][0] = e.bubble ? entry_t'('0) : entry_t'({valid, d.wr, d.dst, d.ld});
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic compareAll(input string tag, input out_t got, input out_t exp);
    checkOutput({tag, ".alu_rs"},   32'(got.aluRs),    32'(exp.aluRs));
    checkOutput({tag, ".alu_rt"},   32'(got.aluRt),    32'(exp.aluRt));
    checkOutput({tag, ".mem_rs"},   32'(got.memRs),    32'(exp.memRs));
    checkOutput({tag, ".mem_rt"},   32'(got.memRt),    32'(exp.memRt));
    checkOutput({tag, ".rt_rd"},    32'(got.rtRd),     32'(exp.rtRd));
    checkOutput({tag, ".wnum_mux"}, 32'(got.wnumMux),  32'(exp.wnumMux));
    checkOutput({tag, ".wnum"},     32'(got.wnum),     32'(exp.wnum));
    checkOutput({tag, ".wr"},       32'(got.wr),       32'(exp.wr));
    checkOutput({tag, ".stall"},    32'(got.stall),    32'(exp.stall));
    checkOutput({tag, ".flush"},    32'(got.flush),    32'(exp.flush));
    checkOutput({tag, ".bubble"},   32'(got.bubble),   32'(exp.bubble));
    checkOutput({tag, ".stall_cnt"}, 32'(got.stallCnt), 32'(exp.stallCnt));
    checkOutput({tag, ".flush_cnt"}, 32'(got.flushCnt), 32'(exp.flushCnt));
  endtask

  // every negedge, both instances against the model
  always @(negedge clk) begin
    if (modelReady) begin
      out_t gotA, gotB;
      gotA = '{aluRsA, aluRtA, memRsA, memRtA, rtRdA, wnumMuxA, wnumA, wrA, stallA,
               flushA, bubbleA, stallCntA, flushCntA, 1'b0};
      gotB = '{aluRsB, aluRtB, memRsB, memRtB, rtRdB, wnumMuxB, wnumB, wrB, stallB,
               flushB, bubbleB, {14'd0, stallCntB}, {14'd0, flushCntB}, 1'b0};
      compareAll("A", gotA, expected(0));
      compareAll("B", gotB, expected(1));
    end
  end

  function automatic logic [31:0] rtype(input logic [4:0] rd, rs, rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, rs);
    return {op, rs, rt, 16'h0004};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic v, br, busy);
    instr   = ins;
    valid   = v;
    branch  = br;
    memBusy = busy;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    instr = 32'h0; valid = 1'b0; branch = 1'b0; memBusy = 1'b0;
    tick(); tick();
    rst = 1'b0;

    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("lit.reset_stall", 32'(stallA), 32'd0);
    checkOutput("lit.reset_wr", 32'(wrA), 32'd0);
    checkOutput("lit.reset_wnum", 32'(wnumA), 32'd0);
    checkOutput("lit.reset_wnum_mux", 32'(wnumMuxA), 32'd1);
    checkOutput("lit.reset_rt_rd", 32'(rtRdA), 32'd1);
    checkOutput("lit.reset_stall_cnt", 32'(stallCntA), 32'd0);
    tick();

    // add r3,r1,r2 ; sub r4,r3,r5
    applyStimulus(rtype(5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    checkOutput("lit.add_alu_rs", 32'(aluRsA), 32'd0);
    tick();
    applyStimulus(rtype(5'd4, 5'd3, 5'd5), 1'b1, 1'b0, 1'b0);
    checkOutput("lit.fwd_alu_rs", 32'(aluRsA), 32'd1);
    checkOutput("lit.fwd_alu_rt", 32'(aluRtA), 32'd0);
    checkOutput("lit.fwd_stall", 32'(stallA), 32'd0);
    tick();
    checkOutput("lit.fwd_stall_cnt", 32'(stallCntA), 32'd0);
    idle(3);

    // lw r3,0(r1) ; add r4,r3,r3
    applyStimulus(itype(6'h23, 5'd3, 5'd1), 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(rtype(5'd4, 5'd3, 5'd3), 1'b1, 1'b0, 1'b0);
    checkOutput("lit.lu_stall", 32'(stallA), 32'd1);
    checkOutput("lit.lu_bubble", 32'(bubbleA), 32'd1);
    checkOutput("lit.lu_alu_rs", 32'(aluRsA), 32'd0);
    tick();
    checkOutput("lit.lu_stall_cnt", 32'(stallCntA), 32'd1);
    checkOutput("lit.lu_stall_cnt_b", 32'(stallCntB), 32'd1);
    applyStimulus(rtype(5'd4, 5'd3, 5'd3), 1'b1, 1'b0, 1'b0);
    checkOutput("lit.lu2_stall", 32'(stallA), 32'd0);
    checkOutput("lit.lu2_mem_rs", 32'(memRsA), 32'd1);
    checkOutput("lit.lu2_mem_rt", 32'(memRtA), 32'd1);
    checkOutput("lit.lu2_alu_rs", 32'(aluRsA), 32'd0);
    tick();
    idle(3);

    // lw r3 in step 4, addi r3 in step 3, reader of r3
    applyStimulus(itype(6'h23, 5'd3, 5'd1), 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(itype(6'h08, 5'd3, 5'd0), 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(rtype(5'd4, 5'd3, 5'd0), 1'b1, 1'b0, 1'b0);
    checkOutput("lit.prio_alu_rs", 32'(aluRsA), 32'd1);
    checkOutput("lit.prio_mem_rs", 32'(memRsA), 32'd0);
    checkOutput("lit.prio_stall", 32'(stallA), 32'd0);
    tick();
    idle(3);

    // same shape with destination r0
    applyStimulus(itype(6'h23, 5'd0, 5'd1), 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(itype(6'h08, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(rtype(5'd4, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
    checkOutput("lit.r0_alu_rs", 32'(aluRsA), 32'd0);
    checkOutput("lit.r0_mem_rs", 32'(memRsA), 32'd0);
    checkOutput("lit.r0_stall", 32'(stallA), 32'd0);
    tick();
    idle(3);

    // taken branch while a load-use hazard is pending
    applyStimulus(itype(6'h23, 5'd3, 5'd1), 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(rtype(5'd4, 5'd3, 5'd3), 1'b1, 1'b1, 1'b0);
    checkOutput("lit.br_flush", 32'(flushA), 32'd1);
    checkOutput("lit.br_bubble", 32'(bubbleA), 32'd1);
    checkOutput("lit.br_stall", 32'(stallA), 32'd0);
    tick();
    checkOutput("lit.br_flush_cnt", 32'(flushCntA), 32'd1);
    checkOutput("lit.br_stall_cnt", 32'(stallCntA), 32'd1);
    idle(3);

    // memory busy with add r7 in step 5
    applyStimulus(rtype(5'd7, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    tick();
    idle(2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("lit.busy_wr", 32'(wrA), 32'd0);
      checkOutput("lit.busy_wnum", 32'(wnumA), 32'd7);
      checkOutput("lit.busy_stall", 32'(stallA), 32'd1);
      checkOutput("lit.busy_bubble", 32'(bubbleA), 32'd0);
      tick();
    end
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("lit.release_wr", 32'(wrA), 32'd1);
    checkOutput("lit.release_wnum", 32'(wnumA), 32'd7);
    tick();
    idle(3);

    // step-5 writer r7, step-2 reader of r7
    applyStimulus(rtype(5'd7, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    tick();
    idle(2);
    applyStimulus(rtype(5'd8, 5'd7, 5'd0), 1'b1, 1'b0, 1'b0);
    checkOutput("lit.s5_stall", 32'(stallA), 32'd1);
    checkOutput("lit.s5_bubble", 32'(bubbleA), 32'd1);
    checkOutput("lit.s5_bypass_stall", 32'(stallB), 32'd0);
    tick();
    checkOutput("lit.s5_stall_cnt", 32'(stallCntA), 32'd2);
    applyStimulus(rtype(5'd8, 5'd7, 5'd0), 1'b1, 1'b0, 1'b0);
    checkOutput("lit.s5_release", 32'(stallA), 32'd0);
    tick();
    idle(3);

    // repeated load-use stalls and flushes to saturate the narrow counters
    for (int i = 0; i < 4; i++) begin
      applyStimulus(itype(6'h23, 5'd3, 5'd1), 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(rtype(5'd4, 5'd3, 5'd3), 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      idle(1);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    checkOutput("lit.sat_stall_a", 32'(stallCntA), 32'd6);
    checkOutput("lit.sat_stall_b", 32'(stallCntB), 32'd3);
    checkOutput("lit.sat_flush_a", 32'(flushCntA), 32'd4);
    checkOutput("lit.sat_flush_b", 32'(flushCntB), 32'd3);
    idle(3);

    // reset in the middle of a load-use stall
    applyStimulus(itype(6'h23, 5'd3, 5'd1), 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(rtype(5'd4, 5'd3, 5'd3), 1'b1, 1'b0, 1'b0);
    checkOutput("lit.rst_pre_stall", 32'(stallA), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(rtype(5'd4, 5'd3, 5'd3), 1'b1, 1'b0, 1'b0);
    checkOutput("lit.rst_stall", 32'(stallA), 32'd0);
    checkOutput("lit.rst_bubble", 32'(bubbleA), 32'd0);
    checkOutput("lit.rst_stall_cnt", 32'(stallCntA), 32'd0);
    checkOutput("lit.rst_flush_cnt_b", 32'(flushCntB), 32'd0);
    tick();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
